// File: rtl/psram_init_pkg.sv
// Shared types and opcodes for the PSRAM power-up command sequencer.
package psram_init_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PWRUP,
      SELECT,
      SHIFT,
      TAIL,
      GAP,
      DONE
   } state_t;

   localparam logic [7:0] CMD_RSTEN    = 8'h66;
   localparam logic [7:0] CMD_RST      = 8'h99;
   localparam logic [7:0] CMD_QPI_EN   = 8'h35;
   localparam logic [7:0] CMD_QPI_EXIT = 8'hF5;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/psram_sck_gen.sv
// SCK divider: toggles every CLK_DIV clk cycles while enabled, parks low otherwise.
// rise/fall flag the cycle whose closing edge moves sck high/low.
module psram_sck_gen #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic sck,
   output logic rise,
   output logic fall
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LD = DW'(CLK_DIV - 1);

   logic [DW-1:0] cnt;
   logic          tick;

   assign tick = en && (cnt == '0);
   assign rise = tick && !sck;
   assign fall = tick && sck;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= DIV_LD;
         sck <= 1'b0;
      end else if (!en) begin
         cnt <= DIV_LD;
         sck <= 1'b0;
      end else if (tick) begin
         cnt <= DIV_LD;
         sck <= ~sck;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/psram_init_seq.sv
// PSRAM power-up sequencer: waits, then issues CMD_LIST as SPI or QPI opcodes.
// state  | meaning
// IDLE   | waiting for start
// PWRUP  | power-up wait
// SELECT | fetch opcode idx, ce_n still high
// SHIFT  | ce_n low, sck toggling out data units
// TAIL   | ce_n low, sck parked, CLK_DIV cycles
// GAP    | ce_n high between commands
// DONE   | sequence complete, pins free for controller
module psram_init_seq
   import psram_init_pkg::*;
#(
   parameter int                    NUM_CMDS     = 3,
   parameter logic [8*NUM_CMDS-1:0] CMD_LIST     = {CMD_QPI_EN, CMD_RST, CMD_RSTEN},
   parameter logic [NUM_CMDS-1:0]   QPI_MASK     = '0,
   parameter int                    CLK_DIV      = 1,
   parameter int                    CE_GAP       = 4,
   parameter int                    PWRUP_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       sck,
   output logic       ce_n,
   output logic [3:0] dout,
   output logic       douten
);

   localparam int CW = $clog2(max_of(max_of(PWRUP_CYCLES, CE_GAP),
                                     max_of(CLK_DIV, NUM_CMDS)) + 1);
   localparam logic [63:0]   CMD_PAD      = 64'(CMD_LIST);
   localparam logic [7:0]    QPI_PAD      = 8'(QPI_MASK);
   localparam logic [CW-1:0] PWRUP_LD     = CW'(PWRUP_CYCLES - 1);
   localparam logic [CW-1:0] TAIL_LD      = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LD       = CW'(CE_GAP - 1);
   // The SELECT cycle also has ce_n high, so mid-sequence gaps count one less.
   localparam logic [CW-1:0] GAP_SHORT_LD = CW'(CE_GAP - 2);

   state_t        state, state_nxt;
   logic [CW-1:0] tmr;
   logic [CW-1:0] idx;
   logic [3:0]    units;
   logic [7:0]    shreg;
   logic          qpi_cur;
   logic [7:0]    sel_op;
   logic          sel_qpi;
   logic          last;
   logic          sck_rise, sck_fall;

   psram_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (state == SHIFT),
      .sck  (sck),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   always_comb begin
      sel_op  = '0;
      sel_qpi = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (int'(idx) == i) begin
            sel_op  = CMD_PAD[8*i +: 8];
            sel_qpi = QPI_PAD[i];
         end
      end
   end

   assign last = (int'(idx) == NUM_CMDS - 1);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = (PWRUP_CYCLES == 0) ? SELECT : PWRUP;
         PWRUP:      if (tmr == '0) state_nxt = SELECT;
         SELECT:     state_nxt = SHIFT;
         SHIFT:      if (sck_fall && units == '0) state_nxt = TAIL;
         TAIL:       if (tmr == '0) state_nxt = (!last && CE_GAP == 1) ? SELECT : GAP;
         GAP:        if (tmr == '0) state_nxt = last ? DONE : SELECT;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tmr     <= '0;
         idx     <= '0;
         units   <= '0;
         shreg   <= '0;
         qpi_cur <= 1'b0;
         dout    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  idx <= '0;
                  tmr <= PWRUP_LD;
               end
            end
            PWRUP: if (tmr != '0) tmr <= tmr - 1'b1;
            SELECT: begin
               qpi_cur <= sel_qpi;
               units   <= sel_qpi ? 4'd2 : 4'd8;
               if (sel_qpi) begin
                  dout  <= sel_op[7:4];
                  shreg <= {sel_op[3:0], 4'h0};
               end else begin
                  dout  <= {3'b000, sel_op[7]};
                  shreg <= {sel_op[6:0], 1'b0};
               end
            end
            SHIFT: begin
               if (sck_rise) units <= units - 1'b1;
               if (sck_fall) begin
                  if (units == '0) begin
                     tmr <= TAIL_LD;
                  end else if (qpi_cur) begin
                     dout  <= shreg[7:4];
                     shreg <= {shreg[3:0], 4'h0};
                  end else begin
                     dout  <= {3'b000, shreg[7]};
                     shreg <= {shreg[6:0], 1'b0};
                  end
               end
            end
            TAIL: begin
               if (tmr == '0) begin
                  dout <= '0;
                  if (last)             tmr <= GAP_LD;
                  else if (CE_GAP == 1) idx <= idx + 1'b1;
                  else                  tmr <= GAP_SHORT_LD;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            GAP: begin
               if (tmr == '0) begin
                  if (!last) idx <= idx + 1'b1;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ce_n   = !(state == SHIFT || state == TAIL);
   assign douten = ~ce_n;
   assign busy   = (state != IDLE) && (state != DONE);
   assign done   = (state == DONE);

endmodule
